// File: rtl/led_arbiter_if.sv
// Request/grant and LED bundle between status sources and led_arbiter.
// The master side is the requesters; the slave side is the arbiter.
interface led_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] pattern;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic               led_r;
    logic               led_g;
    logic               led_b;

    modport master (
        output req,
        output pattern,
        input  grant,
        input  busy,
        input  led_r,
        input  led_g,
        input  led_b
    );

    modport slave (
        input  req,
        input  pattern,
        output grant,
        output busy,
        output led_r,
        output led_g,
        output led_b
    );
endinterface

// File: rtl/led_arbiter.sv
// Round-robin owner of the RGB LED with minimum display time and a green heartbeat when idle.
// Optional LED_ARB_PREEMPT_EN makes requester 0 preempt any other owner.
module led_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 13_500_000,
    parameter int HB_BIT      = 21
) (
    input  logic         clk,
    input  logic         rst,
    led_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OWN
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         rgb_q, rgb_d;
    logic [2:0]         led_q, led_d;
    logic [23:0]        hb_q, hb_d;

    logic               doGrant;
    logic [IDX_W-1:0]   grantIdx;
    logic [IDX_W-1:0]   pickIdx;
    logic               ownerReq;
    logic               releaseOk;
    logic [N_REQ-1:0]   grantOh;

    // First asserted request after 'from', wrapping; 'from' itself is checked last.
    function automatic logic [IDX_W-1:0] rrPick(input logic [N_REQ-1:0] r,
                                                input logic [IDX_W-1:0] from);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = from;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(from) + k) % N_REQ;
            if (r[idx]) begin
                pick = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] sliceOf(input logic [3*N_REQ-1:0] p,
                                           input logic [IDX_W-1:0]   idx);
        return p[3*int'(idx) +: 3];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            rgb_q   <= '0;
            led_q   <= '0;
            hb_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rgb_q   <= rgb_d;
            led_q   <= led_d;
            hb_q    <= hb_d;
        end
    end

    // last_q equals the owner whenever the LED is owned, so one search serves idle and handover.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rgb_d     = rgb_q;
        hb_d      = hb_q + 24'd1;
        doGrant   = 1'b0;
        grantIdx  = owner_q;
        pickIdx   = rrPick(bus.req, last_q);
        ownerReq  = bus.req[owner_q];
        releaseOk = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    doGrant  = 1'b1;
                    grantIdx = pickIdx;
                end
            end
            HOLD, OWN: begin
                if (ownerReq) begin
                    rgb_d = sliceOf(bus.pattern, owner_q);
                end
                releaseOk = (state_q == OWN) || (cnt_q == CNT_W'(HOLD_CYCLES - 1));
                if (!releaseOk) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (ownerReq) begin
                    state_d = OWN;
                end else if (|bus.req) begin
                    doGrant  = 1'b1;
                    grantIdx = pickIdx;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef LED_ARB_PREEMPT_EN
        if ((state_q != IDLE) && (owner_q != '0) && bus.req[0]) begin
            doGrant  = 1'b1;
            grantIdx = '0;
        end
`endif

        if (doGrant) begin
            state_d = HOLD;
            owner_d = grantIdx;
            last_d  = grantIdx;
            cnt_d   = '0;
            rgb_d   = sliceOf(bus.pattern, grantIdx);
        end
    end

    // LEDs are registered from the next-state view so they move on the same edge as grant.
    always_comb begin
        grantOh = '0;
        if (state_q != IDLE) begin
            grantOh[owner_q] = 1'b1;
        end
        if (state_d == IDLE) begin
            led_d = {1'b0, hb_d[HB_BIT], 1'b0};
        end else begin
            led_d = rgb_d;
        end
    end

    assign bus.grant = grantOh;
    assign bus.busy  = (state_q != IDLE);
    assign bus.led_r = led_q[2];
    assign bus.led_g = led_q[1];
    assign bus.led_b = led_q[0];

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with a queue of expected grant/LED values per cycle.
// Build with LED_ARB_PREEMPT_EN defined to exercise the preemption path.
module tb_led_arbiter;

    localparam int N_REQ       = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int HB_BIT      = 3;

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic [2:0] rgb;
        bit         useHb;
    } exp_t;

    logic  clk;
    logic  rst;
    int    compareCount;
    int    failCount;
    int    cycleCount;
    exp_t  expQ[$];

    led_arbiter_if #(.N_REQ(N_REQ)) bus ();

    led_arbiter #(
        .N_REQ      (N_REQ),
        .HOLD_CYCLES(HOLD_CYCLES),
        .HB_BIT     (HB_BIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset; its HB_BIT is the expected idle green.
    always @(posedge clk) begin
        if (rst) cycleCount <= 0;
        else     cycleCount <= cycleCount + 1;
    end

    task automatic applyStimulus(input logic [3:0] r, input logic [11:0] p);
        bus.req     = r;
        bus.pattern = p;
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [2:0] expRgb;
        logic [2:0] gotRgb;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            compareCount++;
            failCount++;
            $error("FAIL scoreboard_empty got grant=%b want an expectation entry", bus.grant);
        end else begin
            e      = expQ.pop_front();
            expRgb = e.useHb ? {1'b0, cycleCount[HB_BIT], 1'b0} : e.rgb;
            gotRgb = {bus.led_r, bus.led_g, bus.led_b};
            compareCount++;
            assert (bus.grant === e.grant) else begin
                failCount++;
                $error("FAIL %s_grant got=%b want=%b", e.tag, bus.grant, e.grant);
            end
            compareCount++;
            assert (bus.busy === (|e.grant)) else begin
                failCount++;
                $error("FAIL %s_busy got=%b want=%b", e.tag, bus.busy, |e.grant);
            end
            compareCount++;
            assert (gotRgb === expRgb) else begin
                failCount++;
                $error("FAIL %s_led got=%b want=%b", e.tag, gotRgb, expRgb);
            end
            compareCount++;
            assert ($onehot0(bus.grant) === 1'b1) else begin
                failCount++;
                $error("FAIL %s_onehot got=%b want=at_most_one_bit", e.tag, bus.grant);
            end
        end
    endtask

    task automatic runChecks(input string tag, input logic [3:0] g,
                             input logic [2:0] rgb, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag   = tag;
            e.grant = g;
            e.rgb   = rgb;
            e.useHb = 1'b0;
            expQ.push_back(e);
        end
        for (int i = 0; i < n; i++) checkOutput();
    endtask

    task automatic runIdle(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag   = tag;
            e.grant = 4'b0000;
            e.rgb   = 3'b000;
            e.useHb = 1'b1;
            expQ.push_back(e);
        end
        for (int i = 0; i < n; i++) checkOutput();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] patAll;
        logic [3:0]  oh;
        int          o;

        compareCount = 0;
        failCount    = 0;
        rst          = 1'b1;
        applyStimulus(4'b0000, 12'h000);
        @(posedge clk);
        #1;
        runChecks("reset", 4'b0000, 3'b000, 1);
        rst = 1'b0;

        // Idle heartbeat: green follows bit 3 of the edge count.
        runIdle("idle_hb", 32);

        // Single requester drops early but keeps the LED for the full hold time.
        applyStimulus(4'b0010, 12'b000_000_101_000);
        runChecks("single_hold", 4'b0010, 3'b101, 2);
        applyStimulus(4'b0000, 12'b000_000_101_000);
        runChecks("single_hold", 4'b0010, 3'b101, 6);
        runIdle("single_idle", 2);

        // Round robin from reset with all four requesting.
        rst = 1'b1;
        runChecks("rr_reset", 4'b0000, 3'b000, 1);
        rst    = 1'b0;
        patAll = 12'b100_011_010_001;
        applyStimulus(4'b1111, patAll);
        for (int k = 0; k < 5; k++) begin
            o  = k % 4;
            oh = 4'(1 << o);
            for (int c = 1; c <= 10; c++) begin
                runChecks("rr_order", oh, patAll[3*o +: 3], 1);
                if (c == 1) applyStimulus(4'b1111, patAll);
            end
            if (k == 4) applyStimulus(4'b0000, patAll);
            else        applyStimulus(4'b1111 & ~oh, patAll);
        end
        runIdle("rr_idle", 2);

        // Pattern tracking while requested, frozen after the owner lets go.
        applyStimulus(4'b0100, 12'b000_001_000_000);
        runChecks("pat_first", 4'b0100, 3'b001, 2);
        applyStimulus(4'b0100, 12'b000_110_000_000);
        runChecks("pat_change", 4'b0100, 3'b110, 2);
        applyStimulus(4'b0000, 12'b000_110_000_000);
        runChecks("pat_drop", 4'b0100, 3'b110, 1);
        applyStimulus(4'b0000, 12'b000_011_000_000);
        runChecks("pat_frozen", 4'b0100, 3'b110, 3);
        runIdle("pat_idle", 2);

        // Reset in the middle of a hold, then round robin restarts from index 0.
        applyStimulus(4'b0100, 12'b000_001_010_000);
        runChecks("mid_hold", 4'b0100, 3'b001, 2);
        rst = 1'b1;
        runChecks("mid_reset", 4'b0000, 3'b000, 1);
        rst = 1'b0;
        applyStimulus(4'b0110, 12'b000_001_010_000);
        runChecks("post_reset", 4'b0010, 3'b010, 1);
        applyStimulus(4'b0000, 12'b000_001_010_000);
        runChecks("post_reset", 4'b0010, 3'b010, 7);
        runIdle("post_idle", 2);

        // Requester 0 arrives while requester 3 is holding.
        applyStimulus(4'b1000, 12'b100_000_000_111);
        runChecks("pre_own3", 4'b1000, 3'b100, 2);
        applyStimulus(4'b1001, 12'b100_000_000_111);
`ifdef LED_ARB_PREEMPT_EN
        runChecks("preempt0", 4'b0001, 3'b111, 1);
        applyStimulus(4'b1000, 12'b100_000_000_111);
        runChecks("preempt0", 4'b0001, 3'b111, 7);
        runChecks("back_to3", 4'b1000, 3'b100, 1);
        applyStimulus(4'b0000, 12'b100_000_000_111);
        runChecks("back_to3", 4'b1000, 3'b100, 7);
`else
        runChecks("no_preempt", 4'b1000, 3'b100, 8);
        applyStimulus(4'b0001, 12'b100_000_000_111);
        runChecks("then_own0", 4'b0001, 3'b111, 1);
        applyStimulus(4'b0000, 12'b100_000_000_111);
        runChecks("then_own0", 4'b0001, 3'b111, 7);
`endif
        runIdle("final_idle", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
